alu_cdb_unit: RTL
=================

Name: alu_cdb_unit

Overview:
- Integer execute stage directly downstream of the reservation station (Rs).
- Each cycle, takes at most one ready op from Rs: opcode, ROB id, two operand values, immediate, PC.
- Computes the RV32I result and, for control-flow ops, the taken flag and target.
- Queues results in a small FIFO and presents them on the ALU broadcast bus (`is_alu_ok` / `rob_id_from_alu` / `res_from_alu`) to Rs, ROB and LSB under CDB-grant backpressure.

Parameters:
- DEPTH, 4, result FIFO entries (power of two, >= 2).
- PTR_W, 2, log2(DEPTH).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low: state clears on a rising clk edge while rst==0.
- rdy  in  1  global enable; when 0, all state holds.
- clear  in  1  misprediction flush, synchronous, active-high.
- work_en  in  1  op valid from Rs.
- rob_id_from_rs  in  4  destination ROB id.
- opcode_from_rs  in  6  operation code (encoding below).
- val1  in  32  rs1 value.
- val2  in  32  rs2 value.
- imm_from_rs  in  32  sign-extended immediate.
- pc_from_rs  in  32  instruction PC.
- cdb_grant  in  1  bus arbiter accepts the head entry this cycle.
- alu_full  out  1  Rs must not launch a new op next cycle.
- is_alu_ok  out  1  head entry valid.
- rob_id_from_alu  out  4  head ROB id.
- res_from_alu  out  32  head result (rd value).
- is_jump  out  1  head op redirects control flow.
- jump_target  out  32  head redirect target.
- overflow  out  1  sticky: push was dropped while the FIFO was full.

Behaviour:
- Opcode encoding:
  - 0 LUI, 1 AUIPC, 2 JAL, 3 JALR
  - 4 BEQ, 5 BNE, 6 BLT, 7 BGE, 8 BLTU, 9 BGEU
  - 10 ADDI, 11 SLTI, 12 SLTIU, 13 XORI, 14 ORI, 15 ANDI, 16 SLLI, 17 SRLI, 18 SRAI
  - 19 ADD, 20 SUB, 21 SLL, 22 SLT, 23 SLTU, 24 XOR, 25 SRL, 26 SRA, 27 OR, 28 AND
  - 29..63: result 0, is_jump 0; still pushed.
- Second operand: imm for opcodes 10-18, val2 for 19-28.
- Shift amount: low 5 bits of the second operand only.
- SLT/SLTI compare signed; SLTU/SLTIU/BLTU/BGEU compare unsigned. Set-type results are 32'd0 or 32'd1.
- All arithmetic is mod 2^32.
- LUI: res = imm. AUIPC: res = pc + imm.
- JAL: res = pc + 4; target = pc + imm; is_jump = 1.
- JALR: res = pc + 4; target = (val1 + imm) & ~1; is_jump = 1.
- Branches: res = 0; is_jump = condition taken; target = pc + imm; when not taken, target = pc + 4.
- Non-control ops: is_jump = 0, target = 0.
- Compute is combinational from the Rs outputs. The entry is written into the FIFO at the edge that samples work_en = 1.
- Latency: an op sampled at edge t is visible on is_alu_ok after edge t, provided the FIFO was empty or it is at the head.
- Output ports reflect FIFO head storage combinationally. is_alu_ok = (count != 0). When count == 0, data outputs hold their last value; consumers ignore them.
- Pop occurs when is_alu_ok && cdb_grant at an edge.
- Push and pop in the same cycle: count unchanged; the pushed entry enters at the tail.
- Pointers wrap modulo DEPTH.
- alu_full = (count >= DEPTH-1), combinational. This accounts for the op Rs has already registered.
- Push when count == DEPTH without a same-cycle pop: entry dropped, overflow set to 1, count unchanged. Only clearable by rst.
- rst == 0 at an edge, regardless of rdy: count = 0, pointers = 0, overflow = 0. Thus is_alu_ok = 0 and alu_full = 0.
- clear == 1 with rst high, regardless of rdy: count and pointers = 0. Any push that cycle is discarded. overflow holds.
- rdy == 0: no push, no pop, all state holds. work_en and cdb_grant are ignored.
- Priority: rst > clear > rdy-gated operation.

Test Plan:
- rst low 1 edge, then ADD: val1 = 5, val2 = 0xFFFFFFFD, rob_id 3, grant 1 -> next cycle is_alu_ok = 1, rob_id_from_alu = 3, res = 2; following cycle is_alu_ok = 0.
- SRA val1 = 0x80000000, val2 = 0x24; SLTU val1 = 1, val2 = 0xFFFFFFFF; SLT same operands -> res 0xF8000000; res 1; res 0.
- BLT pc = 0x100, imm = 0x20, val1 = -1, val2 = 1 -> is_jump = 1, target = 0x120, res 0. BGEU with the same operands -> is_jump = 1 (unsigned 0xFFFFFFFF >= 1). JALR val1 = 0x203, imm = 0 -> target 0x202, res = pc + 4.
- cdb_grant held 0 while issuing 3 ops -> alu_full rises after the 3rd push (count 3). A 4th op is still accepted (count 4). Then grant 1 -> results drain in issue order, one per cycle.
- Fill to 4 with grant 0, push a 5th -> overflow = 1, count stays 4, the 5th result is never seen. Push + grant in the same cycle at count 4 -> accepted, count stays 4.
- 2 entries queued, assert clear together with work_en -> next cycle is_alu_ok = 0, alu_full = 0. rdy = 0 with work_en = 1 -> no entry appears.

Source files
------------

// File: rtl/alu_cdb_unit.sv
// RV32I integer execute stage: combinational ALU/branch unit feeding a small
// result FIFO that broadcasts on the ALU CDB under grant backpressure.
module alu_cdb_unit #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clear,
  input  logic        work_en,
  input  logic [3:0]  rob_id_from_rs,
  input  logic [5:0]  opcode_from_rs,
  input  logic [31:0] val1,
  input  logic [31:0] val2,
  input  logic [31:0] imm_from_rs,
  input  logic [31:0] pc_from_rs,
  input  logic        cdb_grant,
  output logic        alu_full,
  output logic        is_alu_ok,
  output logic [3:0]  rob_id_from_alu,
  output logic [31:0] res_from_alu,
  output logic        is_jump,
  output logic [31:0] jump_target,
  output logic        overflow
);

  typedef enum logic [5:0] {
    OP_LUI  = 6'd0,  OP_AUIPC = 6'd1,  OP_JAL  = 6'd2,  OP_JALR = 6'd3,
    OP_BEQ  = 6'd4,  OP_BNE   = 6'd5,  OP_BLT  = 6'd6,  OP_BGE  = 6'd7,
    OP_BLTU = 6'd8,  OP_BGEU  = 6'd9,
    OP_ADDI = 6'd10, OP_SLTI  = 6'd11, OP_SLTIU = 6'd12, OP_XORI = 6'd13,
    OP_ORI  = 6'd14, OP_ANDI  = 6'd15, OP_SLLI = 6'd16, OP_SRLI = 6'd17,
    OP_SRAI = 6'd18,
    OP_ADD  = 6'd19, OP_SUB   = 6'd20, OP_SLL  = 6'd21, OP_SLT  = 6'd22,
    OP_SLTU = 6'd23, OP_XOR   = 6'd24, OP_SRL  = 6'd25, OP_SRA  = 6'd26,
    OP_OR   = 6'd27, OP_AND   = 6'd28
  } op_e;

  typedef struct packed {
    logic [3:0]  rob_id;
    logic [31:0] res;
    logic        jump;
    logic [31:0] target;
  } entry_t;

  localparam logic [PTR_W:0] FULL_CNT   = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] ALMOST_CNT = (PTR_W+1)'(DEPTH - 1);

  // ---------------- combinational execute ----------------
  logic [31:0] op2, pc_plus4, br_target;
  logic [4:0]  shamt;
  logic        lt_s, lt_u, eq;
  entry_t      new_entry;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    new_entry = '0;
    op2       = (opcode_from_rs inside {[6'd10:6'd18]}) ? imm_from_rs : val2;
    shamt     = op2[4:0];
    pc_plus4  = pc_from_rs + 32'd4;
    br_target = pc_from_rs + imm_from_rs;
    lt_s      = $signed(val1) < $signed(op2);
    lt_u      = val1 < op2;
    eq        = val1 == op2;
    new_entry.rob_id = rob_id_from_rs;
    case (opcode_from_rs)
      OP_LUI:   new_entry.res = imm_from_rs;
      OP_AUIPC: new_entry.res = br_target;
      OP_JAL: begin
        new_entry.res    = pc_plus4;
        new_entry.jump   = 1'b1;
        new_entry.target = br_target;
      end
      OP_JALR: begin
        new_entry.res    = pc_plus4;
        new_entry.jump   = 1'b1;
        new_entry.target = (val1 + imm_from_rs) & ~32'd1;
      end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        case (opcode_from_rs)
          OP_BEQ:  new_entry.jump = eq;
          OP_BNE:  new_entry.jump = !eq;
          OP_BLT:  new_entry.jump = lt_s;
          OP_BGE:  new_entry.jump = !lt_s;
          OP_BLTU: new_entry.jump = lt_u;
          default: new_entry.jump = !lt_u;
        endcase
        new_entry.target = new_entry.jump ? br_target : pc_plus4;
      end
      OP_ADDI, OP_ADD:   new_entry.res = val1 + op2;
      OP_SUB:            new_entry.res = val1 - op2;
      OP_SLTI, OP_SLT:   new_entry.res = {31'b0, lt_s};
      OP_SLTIU, OP_SLTU: new_entry.res = {31'b0, lt_u};
      OP_XORI, OP_XOR:   new_entry.res = val1 ^ op2;
      OP_ORI, OP_OR:     new_entry.res = val1 | op2;
      OP_ANDI, OP_AND:   new_entry.res = val1 & op2;
      OP_SLLI, OP_SLL:   new_entry.res = val1 << shamt;
      OP_SRLI, OP_SRL:   new_entry.res = val1 >> shamt;
      OP_SRAI, OP_SRA:   new_entry.res = 32'($signed(val1) >>> shamt);
      default:           new_entry.res = 32'd0;
    endcase
  end

  // ---------------- result FIFO ----------------
  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [PTR_W:0]   count;
  logic             pop_ok, push_ok;

  assign pop_ok  = (count != '0) && cdb_grant;
  // A push into a full FIFO still fits when the head leaves in the same cycle.
  assign push_ok = work_en && ((count != FULL_CNT) || pop_ok);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy) begin
      if (push_ok) tail <= tail + PTR_W'(1);
      if (pop_ok)  head <= head + PTR_W'(1);
      if (work_en && !push_ok) overflow <= 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; is_alu_ok qualifies the data, so stale entries are harmless.
  always_ff @(posedge clk) begin
    if (rst && !clear && rdy && push_ok) mem[tail] <= new_entry;
  end

  entry_t head_entry;
  assign head_entry      = mem[head];
  assign is_alu_ok       = (count != '0);
  assign alu_full        = (count >= ALMOST_CNT);
  assign rob_id_from_alu = head_entry.rob_id;
  assign res_from_alu    = head_entry.res;
  assign is_jump         = head_entry.jump;
  assign jump_target     = head_entry.target;

endmodule
